cvp14_mem_resp: RTL

CVP14_MEM_RESP -- requirements
Module: cvp14_mem_resp

---
 rtl/cvp14_mem_resp_pkg.sv | 30 +++
 rtl/cvp14_wbuf.sv | 114 +++++++++++
 rtl/cvp14_mem_resp.sv | 103 ++++++++++
 3 files changed

// File: rtl/cvp14_mem_resp_pkg.sv
// Shared definitions for the CVP14 memory responder slice.
//   DW       : data word width (fixed at 16)
//   AW_DEF   : default RAM index width
//   WBD_DEF  : default write-buffer depth
//   cyc_e    : per-edge cycle class, encoded as {RD, WR}
//   buf_state_e : write-buffer occupancy state
package cvp14_mem_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned AW_DEF  = 10;
  localparam int unsigned WBD_DEF = 4;

  typedef enum logic [1:0] {
    CYC_IDLE     = 2'b00,
    CYC_WRITE    = 2'b01,
    CYC_READ     = 2'b10,
    CYC_CONFLICT = 2'b11
  } cyc_e;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_PARTIAL,
    BUF_FULL
  } buf_state_e;

  function automatic cyc_e cyc_decode(input logic rd, input logic wr);
    return cyc_e'({rd, wr});
  endfunction

endpackage

// File: rtl/cvp14_wbuf.sv
// Write buffer for cvp14_mem_resp: circular FIFO of {index, data} entries
// with a combinational youngest-match lookup used for read forwarding.
//   Clk1, Reset          : clock, synchronous active-high reset
//   push, push_idx/data  : enqueue at tail
//   pop                  : retire head entry (may coincide with push when full)
//   look_idx             : index to search; look_hit/look_data = youngest match
//   head_idx, head_data  : entry at head, committed to RAM by the top on pop
//   full, empty          : occupancy flags (registered state)
module cvp14_wbuf
  import cvp14_mem_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned WBD = WBD_DEF
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_idx,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] look_idx,
  output logic          look_hit,
  output logic [DW-1:0] look_data,
  output logic [AW-1:0] head_idx,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (WBD > 1) ? $clog2(WBD) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [AW-1:0] idx_q  [WBD];
  logic [AW-1:0] idx_d  [WBD];
  logic [DW-1:0] data_q [WBD];
  logic [DW-1:0] data_d [WBD];
  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  cnt_t          count_q, count_d;
  buf_state_e    state_q, state_d;
  ptr_t          pos;

  // When full, push and pop share the same slot: head data is read from the
  // registered array before the push overwrites it at the edge.
  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      idx_d[tail_q]  = push_idx;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d == '0) begin
      state_d = BUF_EMPTY;
    end else if (count_d == cnt_t'(WBD)) begin
      state_d = BUF_FULL;
    end else begin
      state_d = BUF_PARTIAL;
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= BUF_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Entry storage needs no reset: validity comes from head/count alone.
  always_ff @(posedge Clk1) begin
    idx_q  <= idx_d;
    data_q <= data_d;
  end

  // Walk valid entries oldest to newest so the last hit is the youngest.
  always_comb begin
    look_hit  = 1'b0;
    look_data = '0;
    pos       = '0;
    for (int unsigned i = 0; i < WBD; i++) begin
      pos = head_q + ptr_t'(i);
      if ((cnt_t'(i) < count_q) && (idx_q[pos] == look_idx)) begin
        look_hit  = 1'b1;
        look_data = data_q[pos];
      end
    end
  end

  assign head_idx  = idx_q[head_q];
  assign head_data = data_q[head_q];
  assign full      = (state_q == BUF_FULL);
  assign empty     = (state_q == BUF_EMPTY);

endmodule

// File: rtl/cvp14_mem_resp.sv
// CVP14 memory responder: single-port word RAM fronted by a posted write
// buffer. Reads return the youngest buffered write to the same index, else
// the RAM word, registered on the sampling edge. Writes drain to RAM on IDLE
// cycles or when a write arrives with the buffer full.
//   Clk1, Reset : clock, synchronous active-high reset
//   Addr        : word address (upper bits beyond AW ignored)
//   RD, WR      : level requests; both high is a protocol error
//   DataIn      : write data
//   DataOut     : registered read data, held in non-read cycles
//   Busy        : write buffer non-empty
//   Err         : one-cycle pulse on RD&WR
module cvp14_mem_resp
  import cvp14_mem_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned WBD = WBD_DEF
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic [DW-1:0] Addr,
  input  logic          RD,
  input  logic          WR,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          Busy,
  output logic          Err
);

  cyc_e          cyc;
  logic [AW-1:0] idx;
  logic          push;
  logic          pop;
  logic          look_hit;
  logic [DW-1:0] look_data;
  logic [AW-1:0] head_idx;
  logic [DW-1:0] head_data;
  logic          full;
  logic          empty;
  logic          addr_hi_unused;

  logic [DW-1:0] ram [2**AW];

  logic [DW-1:0] data_out_q, data_out_d;
  logic          err_q, err_d;

  assign addr_hi_unused = ^Addr[DW-1:AW];

  cvp14_wbuf #(
    .AW  (AW),
    .WBD (WBD)
  ) u_wbuf (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .push      (push),
    .pop       (pop),
    .push_idx  (idx),
    .push_data (DataIn),
    .look_idx  (idx),
    .look_hit  (look_hit),
    .look_data (look_data),
    .head_idx  (head_idx),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // Reset gates push/pop so no buffered write reaches RAM on a reset edge.
  always_comb begin
    cyc        = cyc_decode(RD, WR);
    idx        = Addr[AW-1:0];
    push       = ~Reset && (cyc == CYC_WRITE);
    pop        = ~Reset && (((cyc == CYC_IDLE) && !empty) ||
                            ((cyc == CYC_WRITE) && full));
    data_out_d = data_out_q;
    if (cyc == CYC_READ) begin
      data_out_d = look_hit ? look_data : ram[idx];
    end
    err_d      = (cyc == CYC_CONFLICT);
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  // Pop only occurs in IDLE/WRITE cycles, so the RAM port is never shared
  // with a read.
  always_ff @(posedge Clk1) begin
    if (pop) begin
      ram[head_idx] <= head_data;
    end
  end

  assign DataOut = data_out_q;
  assign Err     = err_q;
  assign Busy    = ~empty;

endmodule
